// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port synchronous 32-bit memory between an instruction-fetch port and a data load/store port.
// Latency: grants and memory controls are combinational; read data returns on f_valid/d_valid one cycle after the grant.
// Backpressure: a requester holds req until its gnt; data wins conflicts, and MEM_ARB_FAIRNESS_EN adds a fetch-starvation override.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [15:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Which port (if any) owns the memory read data arriving this cycle.
    typedef enum logic [1:0] {NONE, FETCH, DATA} pend_t;

    pend_t pend_q;
    pend_t pend_d;
    logic  half_q;      // f_addr[1] of the fetch in flight: selects the halfword
    logic  fetch_pri;   // fetch has starved long enough to beat a data request

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q;

    assign fetch_pri = (starve_q == CNT_W'(STARVE_MAX));

    // Count consecutive denied fetch cycles, saturating at STARVE_MAX; any fetch grant clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else if (f_gnt) begin
            starve_q <= '0;
        end else if (f_req && !fetch_pri) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign fetch_pri  = 1'b0;
    assign unused_cfg = (STARVE_MAX != 0);
`endif

    // Address bits outside the word/halfword select are deliberately ignored so fetches wrap.
    logic unused_addr;
    assign unused_addr = ^{f_addr[31:ADDR_W+2], f_addr[0]};

    // Pending-return register and latched halfword select.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= NONE;
            half_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (f_gnt) begin
                half_q <= f_addr[1];
            end
        end
    end

    // Arbitration and memory drive; also decides who owns next cycle's read data.
    always_comb begin
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pend_d    = NONE;
        if (!reset) begin
            if (f_req && (!d_req || fetch_pri)) begin
                f_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = f_addr[ADDR_W+1:2];
                pend_d   = FETCH;
            end else if (d_req) begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                pend_d    = d_we ? NONE : DATA;
            end
        end
    end

    // A flush in the return cycle kills the fetch result; reset hides any read still in flight.
    assign f_valid = !reset && (pend_q == FETCH) && !f_flush;
    assign d_valid = !reset && (pend_q == DATA);
    assign f_rdata = half_q ? mem_rdata[31:16] : mem_rdata[15:0];
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus pushes expected returns into per-port queues;
// a monitor pops and compares on every f_valid/d_valid, flagging unexpected, late or missing pulses.
// A behavioural single-port RAM with one-cycle read latency sits behind the memory port.
module tb_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_flush;
    logic              f_gnt;
    logic              f_valid;
    logic [15:0]       f_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_flush   (f_flush),
        .f_gnt     (f_gnt),
        .f_valid   (f_valid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural memory: synchronous write, registered read.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    exp_t fq[$];
    exp_t dq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        f_req   = 1'b0;
        d_req   = 1'b0;
        f_flush = 1'b0;
        d_we    = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest expected return, in the expected cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (f_valid) begin
                if (fq.size() == 0) begin
                    chk("f_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = fq.pop_front();
                    chk("f_valid_cycle", cyc, e.cyc);
                    chk("f_rdata", {16'h0, f_rdata}, e.dat);
                end
            end
            if (d_valid) begin
                if (dq.size() == 0) begin
                    chk("d_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = dq.pop_front();
                    chk("d_valid_cycle", cyc, e.cyc);
                    chk("d_rdata", d_rdata, e.dat);
                end
            end
            while (fq.size() > 0 && fq[0].cyc < cyc) begin
                e = fq.pop_front();
                chk("f_valid_missing", 32'd0, 32'd1);
            end
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                e = dq.pop_front();
                chk("d_valid_missing", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        logic fw;
        mem[0] <= 32'h1111_2222;
        mem[1] <= 32'hAAAA_5555;
        mem[2] <= 32'hBEEF_CAFE;
        mem[3] <= 32'h0BAD_F00D;
        reset   = 1'b1;
        f_addr  = 32'h0;
        d_addr  = '0;
        d_wdata = 32'h0;
        idle();
        f_req = 1'b1;
        d_req = 1'b1;
        tick();

        // Reset: requests present but everything held low.
        @(negedge clock);
        chk("rst_f_gnt", f_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_f_valid", f_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        tick();
        reset = 1'b0;
        idle();
        tick();

        // Fetch 0x6: word 1, upper halfword.
        f_req = 1'b1; f_addr = 32'h6;
        @(negedge clock);
        chk("f1_f_gnt", f_gnt, 1);
        chk("f1_d_gnt", d_gnt, 0);
        chk("f1_mem_en", mem_en, 1);
        chk("f1_mem_we", mem_we, 0);
        chk("f1_mem_addr", mem_addr, 1);
        fq.push_back('{cyc + 1, 32'h0000_AAAA});
        tick();
        // Upper address bits ignored: 0xFFFFF004 wraps to word 1, lower halfword.
        f_addr = 32'hFFFF_F004;
        @(negedge clock);
        chk("wrap_mem_addr", mem_addr, 1);
        fq.push_back('{cyc + 1, 32'h0000_5555});
        tick();
        idle();
        tick();

        // Store then load the same address, no forwarding path needed.
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd5; d_wdata = 32'h1234_5678;
        @(negedge clock);
        chk("st_d_gnt", d_gnt, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_addr", mem_addr, 5);
        chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
        tick();
        d_we = 1'b0;
        @(negedge clock);
        chk("ld_d_gnt", d_gnt, 1);
        chk("ld_mem_we", mem_we, 0);
        dq.push_back('{cyc + 1, 32'h1234_5678});
        tick();
        idle();
        tick();

        // Both ports request for 10 cycles.
        f_req = 1'b1; f_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd3;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_FAIRNESS_EN
            fw = (i == 4) || (i == 9);
`else
            fw = 1'b0;
`endif
            @(negedge clock);
            chk("conf_f_gnt", f_gnt, fw);
            chk("conf_d_gnt", d_gnt, !fw);
            if (fw) fq.push_back('{cyc + 1, 32'h0000_CAFE});
            else    dq.push_back('{cyc + 1, 32'h0BAD_F00D});
            tick();
        end
        idle();
        tick();

        // Flush kills the returning fetch; a fetch granted during the flush survives.
        f_req = 1'b1; f_addr = 32'h6;
        @(negedge clock);
        chk("fl_gnt_n", f_gnt, 1);
        tick();
        f_flush = 1'b1; f_addr = 32'h4;
        @(negedge clock);
        chk("fl_gnt_n1", f_gnt, 1);
        chk("fl_f_valid_n1", f_valid, 0);
        fq.push_back('{cyc + 1, 32'h0000_5555});
        tick();
        idle();
        tick();

        // Load granted, then reset in the return cycle: no d_valid.
        d_req = 1'b1; d_addr = 10'd1;
        @(negedge clock);
        chk("lr_d_gnt", d_gnt, 1);
        tick();
        reset = 1'b1; f_req = 1'b1;
        @(negedge clock);
        chk("lr_d_valid", d_valid, 0);
        chk("lr_f_gnt", f_gnt, 0);
        chk("lr_d_gnt", d_gnt, 0);
        chk("lr_mem_en", mem_en, 0);
        chk("lr_mem_we", mem_we, 0);
        tick();
        reset = 1'b0;
        idle();
        @(negedge clock);
        chk("lr_after_d_valid", d_valid, 0);
        tick();

        // Back-to-back fetch, load, fetch.
        f_req = 1'b1; f_addr = 32'h6;
        @(negedge clock);
        chk("b2b_f0", f_gnt, 1);
        fq.push_back('{cyc + 1, 32'h0000_AAAA});
        tick();
        f_req = 1'b0; d_req = 1'b1; d_addr = 10'd5;
        @(negedge clock);
        chk("b2b_d1", d_gnt, 1);
        dq.push_back('{cyc + 1, 32'h1234_5678});
        tick();
        d_req = 1'b0; f_req = 1'b1; f_addr = 32'hA;
        @(negedge clock);
        chk("b2b_f2", f_gnt, 1);
        fq.push_back('{cyc + 1, 32'h0000_BEEF});
        tick();
        idle();
        repeat (4) tick();

        chk("fq_drained", fq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
